// File: rtl/data_bus_responder.sv
// data_bus_responder: single-cycle core data port with word RAM, LEDs, switches, cycle counter and 7-seg scanner
module data_bus_responder #(
    parameter int RAM_WORDS = 64,
    parameter int SCAN_DIV  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int AW = RAM_WORDS > 1 ? $clog2(RAM_WORDS) : 1;
    localparam int PW = SCAN_DIV > 2 ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic [31:0]   ram_q [1 << AW];
    logic [15:0]   ledreg_q, ledreg_d, disp_q, disp_d, sw_meta_q, sw_sync_q;
    logic [31:0]   cyc_q, cyc_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [AW-1:0] ram_idx;
    logic          in_rng, sel_ram, sel_led, sel_sw, sel_disp, sel_cyc;
    logic [3:0]    nib;
    logic          unused_addr;

    assign unused_addr = ^ALUResult;
    assign in_rng   = ALUResult[31:9] == 23'd0;
    assign sel_ram  = in_rng && !ALUResult[8];
    assign sel_led  = in_rng && ALUResult[8:2] == 7'h40;
    assign sel_sw   = in_rng && ALUResult[8:2] == 7'h41;
    assign sel_disp = in_rng && ALUResult[8:2] == 7'h42;
    assign sel_cyc  = in_rng && ALUResult[8:2] == 7'h43;
    assign ram_idx  = ALUResult[AW+1:2];

    always_comb begin
        ReadData = sel_ram  ? ram_q[ram_idx] :
                   sel_led  ? {16'd0, ledreg_q} :
                   sel_sw   ? {16'd0, sw_sync_q} :
                   sel_disp ? {16'd0, disp_q} :
                   sel_cyc  ? cyc_q : 32'd0;
    end

    // RAM has no reset and keeps accepting stores while reset is high
    always_ff @(posedge clk) begin
        if (MemWrite && sel_ram) ram_q[ram_idx] <= WriteData;
    end

    always_comb begin
        ledreg_d = (MemWrite && sel_led) ? WriteData[15:0] : ledreg_q;
        disp_d   = (MemWrite && sel_disp) ? WriteData[15:0] : disp_q;
        cyc_d    = (MemWrite && sel_cyc) ? 32'd0 : cyc_q + 32'd1;
        pre_d    = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        idx_d    = (pre_q == PRE_MAX) ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledreg_q  <= '0;
            disp_q    <= '0;
            cyc_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            pre_q     <= '0;
            idx_q     <= '0;
        end else begin
            ledreg_q  <= ledreg_d;
            disp_q    <= disp_d;
            cyc_q     <= cyc_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
        end
    end

    assign led = ledreg_q;
    assign an  = ~(4'b0001 << idx_q);
    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed vectors and scan/reset sequences for data_bus_responder
module tb_data_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'h200;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic [15:0] sw = 16'd0;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        ck;
        logic [31:0] exp;
    } vec_t;
    vec_t v[16];

    data_bus_responder #(.RAM_WORDS(64), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .sw(sw), .led(led), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite = we;
        ALUResult = a;
        WriteData = d;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus(1'b0, a, 32'd0);
        chk(nm, ReadData, exp);
    endtask

    initial begin
        logic [6:0] gl[4];
        logic [3:0] prev_an;
        logic       found;
        int         slot;
        gl = '{7'b0000000, 7'b0001110, 7'b1000000, 7'b1000000};
        v[0]  = '{1'b1, 32'h004,      32'hDEADBEEF, 1'b0, 32'h0};
        v[1]  = '{1'b1, 32'h0FC,      32'h12345678, 1'b0, 32'h0};
        v[2]  = '{1'b0, 32'h004,      32'h0,        1'b1, 32'hDEADBEEF};
        v[3]  = '{1'b0, 32'h0FC,      32'h0,        1'b1, 32'h12345678};
        v[4]  = '{1'b0, 32'h007,      32'h0,        1'b1, 32'hDEADBEEF};
        v[5]  = '{1'b0, 32'h200,      32'h0,        1'b1, 32'h0};
        v[6]  = '{1'b0, 32'h80000004, 32'h0,        1'b1, 32'h0};
        v[7]  = '{1'b1, 32'h204,      32'h11111111, 1'b1, 32'h0};
        v[8]  = '{1'b0, 32'h004,      32'h0,        1'b1, 32'hDEADBEEF};
        v[9]  = '{1'b1, 32'h100,      32'hFFFFA5C3, 1'b1, 32'h0};
        v[10] = '{1'b0, 32'h100,      32'h0,        1'b1, 32'h0000A5C3};
        v[11] = '{1'b0, 32'h110,      32'h0,        1'b1, 32'h0};
        v[12] = '{1'b1, 32'h110,      32'h1234,     1'b1, 32'h0};
        v[13] = '{1'b1, 32'h0FC,      32'hCAFEF00D, 1'b1, 32'h12345678};
        v[14] = '{1'b0, 32'h0FC,      32'h0,        1'b1, 32'hCAFEF00D};
        v[15] = '{1'b0, 32'h1FC,      32'h0,        1'b1, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_led", {16'd0, led}, 32'h0);
        chk("rst_an", {28'd0, an}, 32'hE);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        rd("rst_ledreg", 32'h100, 32'h0);
        rd("rst_sw", 32'h104, 32'h0);
        rd("rst_disp", 32'h108, 32'h0);
        rd("rst_cyc", 32'h10C, 32'h0);
        reset = 1'b0;
        repeat (10) tick();
        rd("cyc_10", 32'h10C, 32'd10);

        for (int i = 0; i < 16; i++) begin
            bus(v[i].we, v[i].a, v[i].d);
            if (v[i].ck) chk($sformatf("vec%0d", i), ReadData, v[i].exp);
            tick();
        end
        chk("led_a5c3", {16'd0, led}, 32'h0000A5C3);

        sw = 16'h8001;
        rd("sw_0edge", 32'h104, 32'h0);
        tick();
        rd("sw_1edge", 32'h104, 32'h0);
        tick();
        rd("sw_2edge", 32'h104, 32'h00008001);
        bus(1'b1, 32'h104, 32'h0);
        tick();
        rd("sw_ro", 32'h104, 32'h00008001);

        bus(1'b1, 32'h10C, 32'h5);
        tick();
        rd("cyc_clr0", 32'h10C, 32'h0);
        tick();
        rd("cyc_clr1", 32'h10C, 32'h1);
        force dut.cyc_q = 32'hFFFFFFFF;
        rd("cyc_max", 32'h10C, 32'hFFFFFFFF);
        release dut.cyc_q;
        tick();
        rd("cyc_wrap", 32'h10C, 32'h0);

        bus(1'b0, 32'h200, 32'h0);
        prev_an = an;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = (an == 4'b1110) && (prev_an != 4'b1110);
            prev_an = an;
        end
        chk("scan_align", {31'd0, found}, 32'h1);
        chk("scan_seg_pre", {25'd0, seg}, 32'h40);
        bus(1'b1, 32'h108, 32'h000000F8);
        tick();
        bus(1'b0, 32'h200, 32'h0);
        for (int k = 1; k < 20; k++) begin
            slot = (k / 4) % 4;
            chk($sformatf("scan_an%0d", k), {28'd0, an}, {28'd0, ~(4'b0001 << slot)});
            chk($sformatf("scan_seg%0d", k), {25'd0, seg}, {25'd0, gl[slot]});
            tick();
        end

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            found = (an == 4'b1011);
            if (!found) tick();
        end
        chk("mid_scan", {31'd0, found}, 32'h1);
        reset = 1'b1;
        bus(1'b1, 32'h0F0, 32'h0BADF00D);
        tick();
        chk("rst2_an", {28'd0, an}, 32'hE);
        chk("rst2_led", {16'd0, led}, 32'h0);
        chk("rst2_seg", {25'd0, seg}, 32'h40);
        bus(1'b1, 32'h100, 32'h7777);
        tick();
        chk("rst2_ledwr", {16'd0, led}, 32'h0);
        reset = 1'b0;
        rd("rst2_cyc", 32'h10C, 32'h0);
        rd("rst2_disp", 32'h108, 32'h0);
        rd("rst2_sw", 32'h104, 32'h0);
        rd("rst2_ram", 32'h004, 32'hDEADBEEF);
        rd("rst2_ramwr", 32'h0F0, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side bus responder for the single-cycle ARM core: answers the core's load/store accesses (address on ALUResult, store data on WriteData, MemWrite strobe) with a word RAM plus memory-mapped Basys board peripherals. It returns ReadData combinationally in the same cycle, as the single-cycle datapath requires. All state updates on the clock edge: RAM, LED and display registers, the cycle counter, the switch synchronizer and the seven-segment scanner. It sits between the `arm` top and the board pins, replacing a plain data memory.

## Interface
- RAM_WORDS, 64: RAM depth in 32-bit words; power of two, at most 64.
- SCAN_DIV, 100000: clock cycles per seven-segment digit slot; at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Sampled only on the rising clk edge.
- MemWrite  in  1  store strobe from the core.
- ALUResult  in  32  byte address from the core. Bits [1:0] are ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from the address.
- sw  in  16  board switches; asynchronous.
- led  out  16  board LEDs.
- seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- an  out  4  digit anodes, active-low, one-hot.

## Operation
- Address decode uses addr[31:9] == 0. Any other address reads 0, and writes to it are ignored.
  - 0x000–0x0FF: RAM, word index addr[7:2]. When RAM_WORDS < 64, the index is addr[log2(RAM_WORDS)+1:2] and upper index bits alias.
  - 0x100 LEDREG: read/write, 16 bits. Reads return {16'b0, ledreg}. A write stores WriteData[15:0].
  - 0x104 SWITCH: read-only. Reads return {16'b0, sw_sync}. Writes are ignored.
  - 0x108 DISPREG: read/write, 16 bits. Holds 4 hex digits; digit 0 is [3:0] and is shown on an[0].
  - 0x10C CYCLES: 32-bit free-running counter. Reads return the current value. Any write clears it.
  - 0x110–0x1FF: read 0, writes ignored.
- Writes commit at the rising edge when MemWrite=1. Reads are purely combinational from current state. A load and a store to the same address in one cycle returns the old value.
- RAM is not cleared by reset. Its contents after reset are undefined; the bench must write before it reads.
- Switch synchronizer: two flops. sw_sync follows sw after 2 edges.
- Cycle counter: increments by 1 each cycle and wraps from 0xFFFFFFFF to 0. A write to CYCLES loads 0 and suppresses the increment for that cycle.
- Scanner:
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - an = ~(1<<idx). seg shows the hex glyph of DISPREG nibble idx.
  - Glyph values (active-low): 0=1000000, 1=1111001, 8=0000000, F=0001110.
- led = ledreg directly.

## Timing
- Reset values: ledreg=0, led=0, DISPREG=0, CYCLES=0, sw_sync=0, prescaler=0, idx=0, an=4'b1110, seg=7'b1000000 (glyph "0").
- ReadData has zero latency. Register and RAM writes are visible to reads in the cycle after the write edge.
- Reset asserted mid-scan or mid-count: all registers listed above return to their reset values at that edge. Reset does not affect RAM. A write in the same cycle as reset is dropped for registers; it is still performed for RAM.
- Digit dwell time is exactly SCAN_DIV cycles. The first advance occurs SCAN_DIV edges after reset deasserts.
- A DISPREG write changes seg in the next cycle, without waiting for a scan slot.
- sw changes appear in SWITCH reads 2 cycles later.

## Test plan
- Reset, then store 0xDEADBEEF to 0x004 and 0x12345678 to 0x0FC, then load both → reads return the same values. A load of 0x200 returns 0.
- Store 0xFFFFA5C3 to 0x100 → led=0xA5C3 next cycle, and a load of 0x100 returns 0x0000A5C3.
- Set sw=0x8001 → a load of 0x104 returns 0 for 2 cycles, then 0x00008001. A store to 0x104 does not change it.
- Release reset and read 0x10C after 10 cycles → returns 10. Store to 0x10C → the next cycle reads 0, the one after reads 1. Separately, force the counter to 0xFFFFFFFF → the next read is 0.
- With SCAN_DIV=4, store 0x00F8 to 0x108 → an sequence 1110,1101,1011,0111, each held 4 cycles. seg sequence 0000000, 0001110, 1000000, 1000000 (digit 0 = 8, digit 1 = F, digits 2–3 = 0).
- Assert reset mid-scan at idx=2 with ledreg≠0 → next cycle an=1110, led=0, CYCLES=0. RAM word 0x004 still reads 0xDEADBEEF.
